mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and WBU.
- Registers the EX->MEM bundle and issues load/store requests to a variable-latency data RAM over a req/ack handshake.
- Generates store byte strobes and aligned write data, and captures the raw read word.
- Presents a registered MEM->WB bundle under a valid/allowin handshake. Load extraction and sign extension stay downstream in the write-back stage.

Parameters:
- DATAWIDTH, 32, data/address width (matches the `datawidth macro).
- TIMEOUT, 255, maximum cycles to wait for ram_ack before flagging a bus error; legal range 1..255 (8-bit counter).

Ports:
- clk  in  1  stage clock
- rst  in  1  asynchronous active-high reset
- es_to_ms_valid  in  1  EX bundle valid
- ms_allowin  out  1  stage can accept the EX bundle this cycle
- es_ctrl  in  9  one-hot class {B,AUIPC,LUI,JALR,JAL,R,S,L,I}
- es_func3  in  3  width/sign selector
- es_alu_res  in  DATAWIDTH  effective address or ALU result
- es_rs2_data  in  DATAWIDTH  store source
- es_imme, es_pc_add_4, es_pc_add_imme  in  DATAWIDTH each  passthrough
- es_rd  in  5  destination register
- ram_req  out  1  access request
- ram_we  out  1  1 = store
- ram_addr  out  DATAWIDTH  word-aligned address ({alu_res[31:2],2'b00})
- ram_wstrb  out  4  byte enables
- ram_wdata  out  DATAWIDTH  lane-aligned store data
- ram_ack  in  1  access complete; ram_rdata is valid in the same cycle
- ram_rdata  in  DATAWIDTH  read word
- ws_allowin  in  1  write-back stage accepts
- ms_to_ws_valid  out  1  WB bundle valid
- ms_ctrl, ms_func3, ms_alu_res, ms_rs2_data, ms_imme, ms_pc_add_4, ms_pc_add_imme, ms_rd  out  as inputs  registered bundle
- ms_ram_rdata  out  DATAWIDTH  captured read word
- ms_excp  out  2  00 none, 01 misaligned, 10 bus timeout

Behaviour:
- Reset (async, active-high) drives: state EMPTY; ms_to_ws_valid=0; ram_req=0; all bundle registers, ms_ram_rdata, ms_excp and the timeout counter =0.
- States:
  - EMPTY: no valid instruction held.
  - WAIT: memory request outstanding.
  - HOLD: result ready.
- ms_ready_go = (state==HOLD).
- ms_allowin = (state==EMPTY) | (state==HOLD & ws_allowin).
- ms_to_ws_valid = (state==HOLD).
- Accept when es_to_ms_valid & ms_allowin; the bundle is registered on that edge. Next state:
  - WAIT if L or S and aligned;
  - HOLD otherwise, including misaligned accesses, which set ms_excp=01 and issue no RAM access.
- Misalignment rules: halfword (func3[1:0]=01) with addr[0]=1; word (func3[1:0]=10) with addr[1:0]!=0.
- HOLD with ws_allowin high and no accept -> EMPTY.
- HOLD with a simultaneous accept -> directly to the new bundle's state, with zero bubble.
- WAIT:
  - ram_req=1, held from registered values; addr/we/wstrb/wdata stay stable until ack.
  - ram_ack=1 -> capture ram_rdata (stores capture as well; value is don't-care downstream), go HOLD. Earliest completion is 1 cycle after accept.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT: set ms_excp=10, drop req, go HOLD.
  - A late ack in any state other than WAIT is ignored.
- Store strobes:
  - SB: 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: 4'b0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: 4'hF, wdata = rs2.
- Loads drive ram_wstrb=0, ram_we=0.
- rst asserted during WAIT drops ram_req immediately. The RAM must tolerate abandoned requests.
- The counter clears on every accept.

Decomposition:
- Shared package/header holds:
  - ctrl bit indices (I..B);
  - func3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - state encodings;
  - ms_excp codes.
- One sub-module, mem_store_align: combinational strobe/wdata generation plus misalignment detection from func3 and addr[1:0].

Test Plan:
- R-type bundle, alu_res=32'h1234, ws_allowin=1 -> ms_to_ws_valid high the next cycle, no ram_req, back-to-back issue sustains 1 instruction/cycle.
- SB with addr=32'h1003, rs2=32'hA5 -> ram_addr=32'h1000, ram_wstrb=4'b1000, ram_wdata=32'hA5A5A5A5; ack after 3 cycles -> HOLD on the 4th cycle after accept.
- LW at 32'h2000, ram_rdata=32'hDEADBEEF with ack 1 cycle after accept -> ms_ram_rdata=32'hDEADBEEF, ms_excp=00.
- LH at 32'h2001 -> no ram_req, ms_excp=01, valid the next cycle.
- LW with no ack, TIMEOUT=4 -> req held 4 cycles then dropped, ms_excp=10. Hold ws_allowin=0 during HOLD -> ms_allowin=0, bundle stable.
- Assert rst mid-WAIT -> ram_req and ms_to_ws_valid fall asynchronously. After release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control bit positions,
// func3 encodings, FSM states and exception codes.
package mem_stage_pkg;

    // Bit positions inside the one-hot {B,AUIPC,LUI,JALR,JAL,R,S,L,I} vector
    localparam int CTRL_W     = 9;
    localparam int CTRL_I     = 0;
    localparam int CTRL_L     = 1;
    localparam int CTRL_S     = 2;
    localparam int CTRL_R     = 3;
    localparam int CTRL_JAL   = 4;
    localparam int CTRL_JALR  = 5;
    localparam int CTRL_LUI   = 6;
    localparam int CTRL_AUIPC = 7;
    localparam int CTRL_B     = 8;

    // func3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size is carried in func3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // no instruction held
        ST_WAIT  = 2'd1,  // RAM request outstanding
        ST_HOLD  = 2'd2   // result ready for write-back
    } ms_state_t;

    localparam logic [1:0] EXCP_NONE     = 2'b00;
    localparam logic [1:0] EXCP_MISALIGN = 2'b01;
    localparam logic [1:0] EXCP_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mem_stage_if.sv
// Data RAM request/acknowledge bus.
// Handshake: the master raises ram_req with ram_we/ram_addr/ram_wstrb/ram_wdata
// and holds all of them stable until a cycle in which the slave returns
// ram_ack=1; that cycle completes the access and ram_rdata is valid in it.
// The master may withdraw ram_req without an ack (timeout or reset), so the
// slave must tolerate abandoned requests.
interface mem_stage_if #(
    parameter int DATAWIDTH = 32
) ();
    logic                 ram_req;
    logic                 ram_we;
    logic [DATAWIDTH-1:0] ram_addr;
    logic [3:0]           ram_wstrb;
    logic [DATAWIDTH-1:0] ram_wdata;
    logic                 ram_ack;
    logic [DATAWIDTH-1:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/mem_store_align.sv
// Store lane alignment and misalignment detection for one access.
module mem_store_align
    import mem_stage_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 is_mem,
    input  logic                 is_store,
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic [DATAWIDTH-1:0] rs2,
    output logic [3:0]           wstrb,
    output logic [DATAWIDTH-1:0] wdata,
    output logic                 misaligned
);

    // Replicate store data into every lane and pick strobes by size/offset
    always_comb begin
        wstrb      = 4'b0000;
        wdata      = rs2;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {(DATAWIDTH/8){rs2[7:0]}};
            end
            SZ_HALF: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata      = {(DATAWIDTH/16){rs2[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
        if (!is_store) wstrb = 4'b0000;
        if (!is_mem) misaligned = 1'b0;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX bundle, performs the data
// RAM access over req/ack with a timeout, and presents the MEM->WB bundle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [CTRL_W-1:0]    es_ctrl,
    input  logic [2:0]           es_func3,
    input  logic [DATAWIDTH-1:0] es_alu_res,
    input  logic [DATAWIDTH-1:0] es_rs2_data,
    input  logic [DATAWIDTH-1:0] es_imme,
    input  logic [DATAWIDTH-1:0] es_pc_add_4,
    input  logic [DATAWIDTH-1:0] es_pc_add_imme,
    input  logic [4:0]           es_rd,
    mem_stage_if.master          ram,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [CTRL_W-1:0]    ms_ctrl,
    output logic [2:0]           ms_func3,
    output logic [DATAWIDTH-1:0] ms_alu_res,
    output logic [DATAWIDTH-1:0] ms_rs2_data,
    output logic [DATAWIDTH-1:0] ms_imme,
    output logic [DATAWIDTH-1:0] ms_pc_add_4,
    output logic [DATAWIDTH-1:0] ms_pc_add_imme,
    output logic [4:0]           ms_rd,
    output logic [DATAWIDTH-1:0] ms_ram_rdata,
    output logic [1:0]           ms_excp,
    output logic [1:0]           dbg_state
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    ms_state_t            state, state_nxt;
    logic [7:0]           wait_cnt;
    logic                 req_we;
    logic [3:0]           req_wstrb;
    logic [DATAWIDTH-1:0] req_wdata;

    logic                 accept;
    logic                 es_is_mem;
    logic                 es_needs_ram;
    logic                 timeout_hit;
    logic [3:0]           al_wstrb;
    logic [DATAWIDTH-1:0] al_wdata;
    logic                 al_misaligned;

    assign es_is_mem      = es_ctrl[CTRL_L] | es_ctrl[CTRL_S];
    assign ms_allowin     = (state == ST_EMPTY) | ((state == ST_HOLD) & ws_allowin);
    assign accept         = es_to_ms_valid & ms_allowin;
    assign es_needs_ram   = es_is_mem & ~al_misaligned;
    assign timeout_hit    = (wait_cnt == TIMEOUT_LAST);
    assign ms_to_ws_valid = (state == ST_HOLD);
    assign dbg_state      = state;

    // Request side is driven purely from registered values, so it stays
    // stable for the whole WAIT period and drops with an async reset.
    assign ram.ram_req   = (state == ST_WAIT);
    assign ram.ram_we    = req_we;
    assign ram.ram_addr  = {ms_alu_res[DATAWIDTH-1:2], 2'b00};
    assign ram.ram_wstrb = req_wstrb;
    assign ram.ram_wdata = req_wdata;

    // Alignment is evaluated on the incoming bundle so the WAIT/HOLD choice
    // can be made on the accept edge with no extra cycle.
    mem_store_align #(.DATAWIDTH(DATAWIDTH)) u_align (
        .is_mem     (es_is_mem),
        .is_store   (es_ctrl[CTRL_S]),
        .size       (es_func3[1:0]),
        .addr_lo    (es_alu_res[1:0]),
        .rs2        (es_rs2_data),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .misaligned (al_misaligned)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next-state: accept from EMPTY/HOLD, complete WAIT on ack or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) state_nxt = es_needs_ram ? ST_WAIT : ST_HOLD;
            end
            ST_WAIT: begin
                if (ram.ram_ack || timeout_hit) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept)          state_nxt = es_needs_ram ? ST_WAIT : ST_HOLD;
                else if (ws_allowin) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Bundle capture on accept; read data / timeout status updated in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_ctrl        <= '0;
            ms_func3       <= '0;
            ms_alu_res     <= '0;
            ms_rs2_data    <= '0;
            ms_imme        <= '0;
            ms_pc_add_4    <= '0;
            ms_pc_add_imme <= '0;
            ms_rd          <= '0;
            ms_ram_rdata   <= '0;
            ms_excp        <= EXCP_NONE;
            req_we         <= 1'b0;
            req_wstrb      <= 4'b0000;
            req_wdata      <= '0;
        end else if (accept) begin
            ms_ctrl        <= es_ctrl;
            ms_func3       <= es_func3;
            ms_alu_res     <= es_alu_res;
            ms_rs2_data    <= es_rs2_data;
            ms_imme        <= es_imme;
            ms_pc_add_4    <= es_pc_add_4;
            ms_pc_add_imme <= es_pc_add_imme;
            ms_rd          <= es_rd;
            ms_excp        <= al_misaligned ? EXCP_MISALIGN : EXCP_NONE;
            req_we         <= es_ctrl[CTRL_S];
            req_wstrb      <= al_wstrb;
            req_wdata      <= al_wdata;
        end else if (state == ST_WAIT) begin
            if (ram.ram_ack)      ms_ram_rdata <= ram.ram_rdata;
            else if (timeout_hit) ms_excp      <= EXCP_TIMEOUT;
        end
    end

    // Wait counter: cleared on accept, counts WAIT cycles without ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   wait_cnt <= 8'd0;
        else if (accept)                           wait_cnt <= 8'd0;
        else if (state == ST_WAIT && !ram.ram_ack) wait_cnt <= wait_cnt + 8'd1;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a
// transaction-level model of one-entry stage occupancy and RAM latency.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
    logic [8:0]    es_ctrl, ms_ctrl;
    logic [2:0]    es_func3, ms_func3;
    logic [DW-1:0] es_alu_res, es_rs2_data, es_imme, es_pc_add_4, es_pc_add_imme;
    logic [DW-1:0] ms_alu_res, ms_rs2_data, ms_imme, ms_pc_add_4, ms_pc_add_imme;
    logic [4:0]    es_rd, ms_rd;
    logic [DW-1:0] ms_ram_rdata;
    logic [1:0]    ms_excp, dbg_state;

    mem_stage_if #(.DATAWIDTH(DW)) ram_if ();

    mem_stage #(.DATAWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_ctrl(es_ctrl), .es_func3(es_func3), .es_alu_res(es_alu_res),
        .es_rs2_data(es_rs2_data), .es_imme(es_imme), .es_pc_add_4(es_pc_add_4),
        .es_pc_add_imme(es_pc_add_imme), .es_rd(es_rd),
        .ram(ram_if),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_ctrl(ms_ctrl), .ms_func3(ms_func3), .ms_alu_res(ms_alu_res),
        .ms_rs2_data(ms_rs2_data), .ms_imme(ms_imme), .ms_pc_add_4(ms_pc_add_4),
        .ms_pc_add_imme(ms_pc_add_imme), .ms_rd(ms_rd),
        .ms_ram_rdata(ms_ram_rdata), .ms_excp(ms_excp), .dbg_state(dbg_state)
    );

    // ---------------- model state ----------------
    typedef struct {
        logic [8:0]  ctrl;
        logic [2:0]  f3;
        logic [31:0] alu, rs2, imme, pc4, pcimm;
        logic [4:0]  rd;
        int          lat;      // ack in this request cycle; 0 = never
        logic [31:0] rdata;
        logic [1:0]  excp;
        bit          is_ram;
        bit          is_store;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } tx_t;

    tx_t src_q[$];
    tx_t exp_q[$];
    tx_t drv;
    bit  drv_valid;
    bit  m_busy, m_ready;
    int  req_cycles;
    int  ws_mode;   // 0 random, 1 always ready, 2 stalled
    bit  rand_en;
    int  n_checks, n_pass, n_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected results straight from the access rules
    function automatic tx_t make_tx(input int cls, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] rs2, input int lat, input logic [31:0] rdata);
        tx_t t;
        int  off, sz;
        bit  mem, mis;
        t.ctrl  = 9'(1) << cls;
        t.f3    = f3;
        t.alu   = addr;
        t.rs2   = rs2;
        t.imme  = $urandom();
        t.pc4   = $urandom();
        t.pcimm = $urandom();
        t.rd    = 5'($urandom_range(0, 31));
        t.lat   = lat;
        t.rdata = rdata;
        off = int'(addr % 4);
        sz  = int'(f3 % 4);
        mem = (cls == CTRL_L) || (cls == CTRL_S);
        mis = mem && ((sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0));
        t.is_ram   = mem && !mis;
        t.is_store = (cls == CTRL_S);
        t.excp  = mis ? 2'd1 : ((t.is_ram && lat == 0) ? 2'd2 : 2'd0);
        t.strb  = 4'd0;
        t.wdata = 32'd0;
        if (t.is_store) begin
            if (sz == 0) begin
                t.strb  = 4'(1 << off);
                t.wdata = (rs2 % 256) * 32'h0101_0101;
            end else if (sz == 1) begin
                t.strb  = 4'(3 << off);
                t.wdata = (rs2 % 65536) * 32'h0001_0001;
            end else begin
                t.strb  = 4'hF;
                t.wdata = rs2;
            end
        end
        return t;
    endfunction

    function automatic tx_t rand_tx();
        int k, cls, lat;
        logic [2:0] f3;
        logic [2:0] lf [5];
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        k = $urandom_range(0, 9);
        if (k <= 2)      cls = CTRL_L;
        else if (k <= 5) cls = CTRL_S;
        else if (k == 6) cls = CTRL_I;
        else             cls = $urandom_range(3, 8);
        if (cls == CTRL_L)      f3 = lf[$urandom_range(0, 4)];
        else if (cls == CTRL_S) f3 = 3'($urandom_range(0, 2));
        else                    f3 = 3'($urandom_range(0, 7));
        lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
        return make_tx(cls, f3, $urandom(), $urandom(), lat, $urandom());
    endfunction

    // ---------------- one cycle: compare, drive, advance model ----------------
    task automatic step();
        bit   exp_allow, acc;
        logic [1:0] exp_st;
        @(negedge clk);
        exp_st = m_ready ? ST_HOLD : (m_busy ? ST_WAIT : ST_EMPTY);
        chk("ms_to_ws_valid", 32'(ms_to_ws_valid), 32'(m_ready));
        chk("ram_req", 32'(ram_if.ram_req), 32'(m_busy && !m_ready));
        chk("dbg_state", 32'(dbg_state), 32'(exp_st));
        if (m_busy && exp_q.size() > 0) begin
            if (m_ready) begin
                chk("ms_ctrl", 32'(ms_ctrl), 32'(exp_q[0].ctrl));
                chk("ms_func3", 32'(ms_func3), 32'(exp_q[0].f3));
                chk("ms_alu_res", ms_alu_res, exp_q[0].alu);
                chk("ms_rs2_data", ms_rs2_data, exp_q[0].rs2);
                chk("ms_imme", ms_imme, exp_q[0].imme);
                chk("ms_pc_add_4", ms_pc_add_4, exp_q[0].pc4);
                chk("ms_pc_add_imme", ms_pc_add_imme, exp_q[0].pcimm);
                chk("ms_rd", 32'(ms_rd), 32'(exp_q[0].rd));
                chk("ms_excp", 32'(ms_excp), 32'(exp_q[0].excp));
                if (exp_q[0].is_ram && exp_q[0].excp == 2'd0)
                    chk("ms_ram_rdata", ms_ram_rdata, exp_q[0].rdata);
            end else begin
                chk("ram_addr", ram_if.ram_addr, exp_q[0].alu & 32'hFFFF_FFFC);
                chk("ram_we", 32'(ram_if.ram_we), 32'(exp_q[0].is_store));
                chk("ram_wstrb", 32'(ram_if.ram_wstrb), 32'(exp_q[0].strb));
                if (exp_q[0].is_store) chk("ram_wdata", ram_if.ram_wdata, exp_q[0].wdata);
            end
        end
        // drive inputs for the coming edge
        case (ws_mode)
            1:       ws_allowin = 1'b1;
            2:       ws_allowin = 1'b0;
            default: ws_allowin = ($urandom_range(0, 3) != 0);
        endcase
        if (!drv_valid) begin
            if (src_q.size() > 0) begin
                drv = src_q.pop_front();
                drv_valid = 1'b1;
            end else if (rand_en && $urandom_range(0, 3) != 0) begin
                drv = rand_tx();
                drv_valid = 1'b1;
            end
        end
        es_to_ms_valid = drv_valid;
        es_ctrl        = drv.ctrl;
        es_func3       = drv.f3;
        es_alu_res     = drv.alu;
        es_rs2_data    = drv.rs2;
        es_imme        = drv.imme;
        es_pc_add_4    = drv.pc4;
        es_pc_add_imme = drv.pcimm;
        es_rd          = drv.rd;
        if (m_busy && !m_ready) begin
            ram_if.ram_ack   = (exp_q[0].lat != 0) && (req_cycles + 1 == exp_q[0].lat);
            ram_if.ram_rdata = ram_if.ram_ack ? exp_q[0].rdata : $urandom();
        end else begin
            // stray acks outside a request must have no effect
            ram_if.ram_ack   = ($urandom_range(0, 7) == 0);
            ram_if.ram_rdata = $urandom();
        end
        #1;
        exp_allow = !m_busy || (m_ready && ws_allowin);
        chk("ms_allowin", 32'(ms_allowin), 32'(exp_allow));
        acc = drv_valid && exp_allow;
        if (m_busy && !m_ready) begin
            req_cycles++;
            if (ram_if.ram_ack || req_cycles == TIMEOUT) m_ready = 1'b1;
        end else if (m_ready && ws_allowin) begin
            exp_q.delete(0);
            m_busy  = 1'b0;
            m_ready = 1'b0;
        end
        if (acc) begin
            exp_q.push_back(drv);
            m_busy     = 1'b1;
            m_ready    = !drv.is_ram;
            req_cycles = 0;
            drv_valid  = 1'b0;
            n_acc++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (!m_busy && !drv_valid && src_q.size() == 0) break;
            step();
        end
        chk("drain_idle", 32'(m_busy || drv_valid), 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        src_q.delete();
        drv_valid  = 1'b0;
        m_busy     = 1'b0;
        m_ready    = 1'b0;
        req_cycles = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        n_checks = 0; n_pass = 0; n_acc = 0;
        rand_en = 1'b0; ws_mode = 1;
        clear_model();
        drv = make_tx(CTRL_R, 3'd0, 32'd0, 32'd0, 0, 32'd0);
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        es_ctrl = '0; es_func3 = '0; es_alu_res = '0; es_rs2_data = '0;
        es_imme = '0; es_pc_add_4 = '0; es_pc_add_imme = '0; es_rd = '0;
        ram_if.ram_ack = 1'b0; ram_if.ram_rdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_req", 32'(ram_if.ram_req), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_excp", 32'(ms_excp), 32'd0);
        chk("rst_alu", ms_alu_res, 32'd0);
        chk("rst_rdata", ms_ram_rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // R-type stream at full rate
        src_q.push_back(make_tx(CTRL_R, 3'd0, 32'h1234, $urandom(), 0, 32'd0));
        for (int i = 0; i < 3; i++) src_q.push_back(make_tx(CTRL_R, 3'd0, $urandom(), $urandom(), 0, 32'd0));
        n0 = n_acc;
        step(); step();
        chk("r_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("r_alu", ms_alu_res, 32'h1234);
        chk("r_noreq", 32'(ram_if.ram_req), 32'd0);
        step(); step();
        chk("r_back_to_back", 32'(n_acc - n0), 32'd4);
        drain();

        // SB at 0x1003, ack in third request cycle
        src_q.push_back(make_tx(CTRL_S, F3_SB, 32'h1003, 32'h0000_00A5, 3, $urandom()));
        step(); step();
        chk("sb_req", 32'(ram_if.ram_req), 32'd1);
        chk("sb_addr", ram_if.ram_addr, 32'h1000);
        chk("sb_wstrb", 32'(ram_if.ram_wstrb), 32'h8);
        chk("sb_wdata", ram_if.ram_wdata, 32'hA5A5_A5A5);
        step(); step();
        chk("sb_not_yet", 32'(ms_to_ws_valid), 32'd0);
        step();
        chk("sb_hold", 32'(ms_to_ws_valid), 32'd1);
        drain();

        // LW with ack one cycle after accept
        src_q.push_back(make_tx(CTRL_L, F3_LW, 32'h2000, $urandom(), 1, 32'hDEAD_BEEF));
        step(); step(); step();
        chk("lw_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lw_rdata", ms_ram_rdata, 32'hDEAD_BEEF);
        chk("lw_excp", 32'(ms_excp), 32'd0);
        drain();

        // Misaligned LH
        src_q.push_back(make_tx(CTRL_L, F3_LH, 32'h2001, $urandom(), 1, $urandom()));
        step(); step();
        chk("lh_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lh_excp", 32'(ms_excp), 32'd1);
        chk("lh_noreq", 32'(ram_if.ram_req), 32'd0);
        drain();

        // LW never acknowledged, write-back stalled
        ws_mode = 2;
        src_q.push_back(make_tx(CTRL_L, F3_LW, 32'h3000, $urandom(), 0, $urandom()));
        step();
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            chk("to_req_held", 32'(ram_if.ram_req), 32'd1);
        end
        src_q.push_back(make_tx(CTRL_R, 3'd0, $urandom(), $urandom(), 0, 32'd0));
        step();
        chk("to_req_dropped", 32'(ram_if.ram_req), 32'd0);
        chk("to_excp", 32'(ms_excp), 32'd2);
        chk("to_allowin", 32'(ms_allowin), 32'd0);
        step(); step();
        chk("to_stable_excp", 32'(ms_excp), 32'd2);
        chk("to_stable_alu", ms_alu_res, 32'h3000);
        ws_mode = 1;
        drain();

        // Reset in the middle of a request, then a clean load
        src_q.push_back(make_tx(CTRL_L, F3_LW, 32'h4000, $urandom(), 0, $urandom()));
        step(); step(); step();
        chk("mid_req", 32'(ram_if.ram_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", 32'(ram_if.ram_req), 32'd0);
        chk("async_valid", 32'(ms_to_ws_valid), 32'd0);
        es_to_ms_valid = 1'b0;
        ram_if.ram_ack = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        src_q.push_back(make_tx(CTRL_L, F3_LW, 32'h4004, $urandom(), 2, 32'hCAFE_F00D));
        step(); step(); step(); step();
        chk("post_rst_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("post_rst_rdata", ms_ram_rdata, 32'hCAFE_F00D);
        chk("post_rst_excp", 32'(ms_excp), 32'd0);
        drain();

        // Randomized traffic
        ws_mode = 0;
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        ws_mode = 1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
